rice_bit_packer: RTL and testbench
==================================

# rice_bit_packer

Serialises Rice codes from the variable Rice encoder stage into a big-endian, MSB-first 16-bit word stream. The upstream stage delivers each residual as a unary quotient count (`iMSB`) and a binary field (`iLSB`, which carries the terminating '1' as its top bit). This block expands the quotient into zeros, appends the binary field and packs the result into a bit accumulator. It sits between the encoder and the frame/output memory writer and applies backpressure through `oReady`, because large quotients take several cycles to expand.

## Interface
- No parameters. Widths are fixed to match the 16-bit encoder datapath.
- `iClock` in 1: rising-edge clock.
- `iReset` in 1: asynchronous, active-low reset (asserted at 0).
- `iValid` in 1: a code is present on `iMSB`/`iLSB`/`iRiceParam`.
- `iMSB` in 16: unary quotient q, range 0..65535. The block emits q '0' bits.
- `iLSB` in 16: binary field; its low `iRiceParam+1` bits are emitted MSB-first. Bits above that are ignored.
- `iRiceParam` in 4: k, aligned with `iValid`. Binary field length is k+1 (1..16).
- `iFlush` in 1: pad the partial word with zeros and emit it.
- `oReady` out 1: the block accepts a code or flush this cycle.
- `oWord` out 16: packed output word; the first-emitted bit is in bit 15.
- `oWordValid` out 1: one-cycle strobe, `oWord` is valid.
- `oFlushDone` out 1: one-cycle strobe, flush complete.

## Operation
- Reset values: state IDLE, accumulator empty (fill=0), `oWord`=0, `oWordValid`=0, `oFlushDone`=0, `oReady`=1.
- State machine: IDLE, UNARY, BINARY, FLUSH.
- `oReady` is 1 only in IDLE.
- Upstream must hold `iValid`/`iFlush` low while `oReady`=0. Inputs presented while `oReady`=0 are ignored.
- IDLE:
  - On `iValid`: latch zr=iMSB, bin=iLSB, blen=iRiceParam+1. Next state is UNARY if zr≠0, else BINARY.
  - On `iFlush` alone: go to FLUSH.
  - On `iValid` and `iFlush` in the same cycle: latch the code, set flush-pending, and process the code first.
- UNARY: each cycle append n=min(zr,16) zeros and set zr=zr−n. When zr reaches 0, go to BINARY.
- BINARY: append the low blen bits of bin in one cycle. Go to FLUSH if flush-pending, else to IDLE.
- FLUSH:
  - If fill>0: emit {remaining bits, zero pad} as one word and set fill=0.
  - Pulse `oFlushDone`, clear flush-pending, return to IDLE.
  - If fill=0: emit no word; `oFlushDone` still pulses.
- Accumulator:
  - 32-bit, left-aligned, with fill range 0..15 between cycles.
  - An append of ≤16 bits makes fill ≤31, so it never overflows.
  - When the post-append fill is ≥16, register the top 16 bits to `oWord`, shift left 16 and set fill −= 16.
  - At most one word is emitted per cycle.
- Bit order: unary zeros first, then the binary field MSB-first (its top bit is the '1' terminator).
- Codes are concatenated with no alignment between codes.
- Reset mid-operation discards the latched code, accumulator contents and pending flush, and returns all outputs to their reset values immediately.

## Timing
- Code occupancy: 1 accept cycle (IDLE) + ceil(q/16) UNARY cycles + 1 BINARY cycle.
  - The next code can be accepted in the cycle after BINARY.
  - With q=0, codes are accepted every 2nd cycle.
- `oWordValid`/`oWord` update on the clock edge that ends the UNARY or BINARY cycle that completed the word.
- `oFlushDone` is asserted on the edge that ends the FLUSH cycle, together with its padded word, if one is emitted.
- `oWordValid` and `oFlushDone` are single-cycle strobes. There is no output backpressure; the consumer must take every strobe.

## Test plan
- **Four identical codes, then flush.** Apply 4× (q=1, k=2, iLSB=3'b110), each at `oReady`. Required: exactly one word, `oWord`=16'h6666, strobed at the end of the 4th BINARY cycle. A following flush gives `oFlushDone` with no word.
- **Long quotient, then flush.** Apply q=20, k=0, iLSB=1, then `iFlush`. Required:
  - `oReady` low for 3 cycles after accept;
  - word 16'h0000 after the first UNARY cycle;
  - after flush, word 16'h0800 and `oFlushDone` on the same edge.
- **Full-width binary field.** Apply q=0, k=15, iLSB=16'hABCD with an empty accumulator. Required: `oWord`=16'hABCD strobed at the end of BINARY, fill=0 afterwards.
- **Worst-case quotient.** Apply q=65535, k=0. Required:
  - 4096 UNARY cycles, producing 4095 words of 16'h0000, then fill=15;
  - BINARY emits 16'h0001;
  - `oReady` returns high 4097 cycles after accept.
- **Simultaneous code and flush.** Apply `iValid`+`iFlush` in one cycle with q=0, k=3, iLSB=4'b1010. Required: code processed, then FLUSH emits 16'hA000 with `oFlushDone`.
- **Reset mid-operation.** Assert reset during UNARY of q=40. Required:
  - all outputs at reset values with no clock edge needed;
  - after release, a flush produces only `oFlushDone` (no word).
  - Also check that `iValid` presented while `oReady`=0 produces no extra bits.

Source files
------------

// File: rtl/rice_bit_packer_if.sv
// Handshake bundle between the Rice encoder, the bit packer and the word consumer.
// The encoder side drives codes and flush requests; the packer drives ready and output words.
interface rice_bit_packer_if;
    logic        iValid;
    logic [15:0] iMSB;
    logic [15:0] iLSB;
    logic [3:0]  iRiceParam;
    logic        iFlush;
    logic        oReady;
    logic [15:0] oWord;
    logic        oWordValid;
    logic        oFlushDone;

    modport master (
        output iValid, iMSB, iLSB, iRiceParam, iFlush,
        input  oReady, oWord, oWordValid, oFlushDone
    );

    modport slave (
        input  iValid, iMSB, iLSB, iRiceParam, iFlush,
        output oReady, oWord, oWordValid, oFlushDone
    );
endinterface

// File: rtl/rice_bit_packer.sv
// Expands Rice codes (unary zeros + binary field) into a big-endian, MSB-first
// 16-bit word stream, with a zero-padded flush of the partial word.
module rice_bit_packer (
    input  logic             iClock,
    input  logic             iReset,
    rice_bit_packer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, UNARY, BINARY, FLUSH} state_t;

    state_t      state;
    logic [31:0] acc;
    logic [4:0]  fill;
    logic [15:0] zr;
    logic [15:0] bin;
    logic [4:0]  blen;
    logic        flush_pend;
    logic [15:0] word_q;
    logic        word_valid_q;
    logic        flush_done_q;

    logic [4:0]  n_zero;
    logic [15:0] bin_al;
    logic [31:0] merged;
    logic [4:0]  fill_sum;

    // Bits of acc below the fill point are always zero, so appending is a plain OR
    // and appending zeros only moves the fill pointer.
    always_comb begin
        n_zero   = (zr[15:4] != 12'd0) ? 5'd16 : {1'b0, zr[3:0]};
        bin_al   = bin << (5'd16 - blen);
        merged   = acc;
        fill_sum = fill;
        if (state == UNARY) begin
            fill_sum = fill + n_zero;
        end else if (state == BINARY) begin
            merged   = acc | ({bin_al, 16'h0000} >> fill);
            fill_sum = fill + blen;
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others, exactly like the hardware.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state        <= IDLE;
            acc          <= 32'h0;
            fill         <= 5'd0;
            zr           <= 16'h0;
            bin          <= 16'h0;
            blen         <= 5'd1;
            flush_pend   <= 1'b0;
            word_q       <= 16'h0;
            word_valid_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            flush_done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.iValid) begin
                        zr         <= bus.iMSB;
                        bin        <= bus.iLSB;
                        blen       <= {1'b0, bus.iRiceParam} + 5'd1;
                        flush_pend <= bus.iFlush;
                        state      <= (bus.iMSB != 16'h0) ? UNARY : BINARY;
                    end else if (bus.iFlush) begin
                        state <= FLUSH;
                    end
                end

                UNARY, BINARY: begin
                    // fill never exceeds 31, so bit 4 alone flags a completed word.
                    if (fill_sum[4]) begin
                        word_q       <= merged[31:16];
                        word_valid_q <= 1'b1;
                        acc          <= {merged[15:0], 16'h0000};
                        fill         <= {1'b0, fill_sum[3:0]};
                    end else begin
                        acc  <= merged;
                        fill <= fill_sum;
                    end
                    if (state == UNARY) begin
                        zr <= zr - {11'd0, n_zero};
                        if (zr == {11'd0, n_zero}) begin
                            state <= BINARY;
                        end
                    end else begin
                        state <= flush_pend ? FLUSH : IDLE;
                    end
                end

                FLUSH: begin
                    if (fill != 5'd0) begin
                        word_q       <= acc[31:16];
                        word_valid_q <= 1'b1;
                    end
                    acc          <= 32'h0;
                    fill         <= 5'd0;
                    flush_pend   <= 1'b0;
                    flush_done_q <= 1'b1;
                    state        <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oReady     = (state == IDLE);
    assign bus.oWord      = word_q;
    assign bus.oWordValid = word_valid_q;
    assign bus.oFlushDone = flush_done_q;

endmodule

// File: tb/tb_rice_bit_packer.sv
// Directed bench for rice_bit_packer: hand-computed word streams, busy lengths,
// flush behaviour, reset mid-code and inputs ignored while busy.
module tb_rice_bit_packer;

    logic iClock = 1'b0;
    logic iReset = 1'b0;
    always #5 iClock = ~iClock;

    rice_bit_packer_if bus ();

    rice_bit_packer dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] words[$];

    // Strobes are registered, so mid-cycle sampling captures each one exactly once.
    always @(negedge iClock) begin
        if (bus.oWordValid) words.push_back(bus.oWord);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!bus.oReady && g < 5000) begin
            tick();
            g++;
        end
        if (!bus.oReady) check("ready_timeout", {31'd0, bus.oReady}, 32'd1);
    endtask

    // Presents one code at oReady and returns the number of cycles oReady stays low.
    task automatic send_code(input logic [15:0] q, input logic [15:0] lsb, input logic [3:0] k,
                             input logic fl, output int busy);
        wait_ready();
        bus.iValid     = 1'b1;
        bus.iMSB       = q;
        bus.iLSB       = lsb;
        bus.iRiceParam = k;
        bus.iFlush     = fl;
        tick();
        bus.iValid = 1'b0;
        bus.iFlush = 1'b0;
        busy = 0;
        while (!bus.oReady && busy < 70000) begin
            tick();
            busy++;
        end
    endtask

    task automatic do_flush(output logic wv, output logic [15:0] w, output logic fd);
        wait_ready();
        bus.iFlush = 1'b1;
        tick();
        bus.iFlush = 1'b0;
        tick();
        wv = bus.oWordValid;
        w  = bus.oWord;
        fd = bus.oFlushDone;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int          busy;
        int          base;
        int          zeros;
        logic        wv;
        logic        fd;
        logic [15:0] w;

        bus.iValid     = 1'b0;
        bus.iMSB       = 16'h0;
        bus.iLSB       = 16'h0;
        bus.iRiceParam = 4'h0;
        bus.iFlush     = 1'b0;
        tick();
        tick();

        check("rst_ready",      {31'd0, bus.oReady},     32'd1);
        check("rst_word_valid", {31'd0, bus.oWordValid}, 32'd0);
        check("rst_word",       {16'd0, bus.oWord},      32'd0);
        check("rst_flush_done", {31'd0, bus.oFlushDone}, 32'd0);
        @(negedge iClock) iReset = 1'b1;
        tick();

        // Four codes 0,110 -> 0110 x4 = 16'h6666 on the 4th BINARY edge.
        base = words.size();
        for (int i = 0; i < 4; i++) begin
            send_code(16'd1, 16'h0006, 4'd2, 1'b0, busy);
            check("t1_busy", busy, 32'd2);
            check("t1_word_valid", {31'd0, bus.oWordValid}, (i == 3) ? 32'd1 : 32'd0);
        end
        check("t1_word", {16'd0, bus.oWord}, 32'h6666);
        tick();
        check("t1_word_count", words.size() - base, 32'd1);
        do_flush(wv, w, fd);
        check("t1_flush_done", {31'd0, fd}, 32'd1);
        check("t1_flush_no_word", {31'd0, wv}, 32'd0);

        // q=20, k=0: one all-zero word, then 00001 left over -> 16'h0800 on flush.
        base = words.size();
        send_code(16'd20, 16'h0001, 4'd0, 1'b0, busy);
        check("t2_busy", busy, 32'd3);
        tick();
        check("t2_word_count", words.size() - base, 32'd1);
        if (words.size() > base) check("t2_first_word", {16'd0, words[base]}, 32'h0000);
        do_flush(wv, w, fd);
        check("t2_flush_valid", {31'd0, wv}, 32'd1);
        check("t2_flush_word", {16'd0, w}, 32'h0800);
        check("t2_flush_done", {31'd0, fd}, 32'd1);

        // Full 16-bit binary field fills exactly one word.
        send_code(16'd0, 16'hABCD, 4'd15, 1'b0, busy);
        check("t3_busy", busy, 32'd1);
        check("t3_word_valid", {31'd0, bus.oWordValid}, 32'd1);
        check("t3_word", {16'd0, bus.oWord}, 32'hABCD);
        do_flush(wv, w, fd);
        check("t3_flush_no_word", {31'd0, wv}, 32'd0);
        check("t3_flush_done", {31'd0, fd}, 32'd1);

        // Worst-case quotient: 4095 zero words, then 15 zeros + '1' = 16'h0001.
        base = words.size();
        send_code(16'hFFFF, 16'h0001, 4'd0, 1'b0, busy);
        check("t4_busy", busy, 32'd4097);
        check("t4_word_valid", {31'd0, bus.oWordValid}, 32'd1);
        check("t4_last_word", {16'd0, bus.oWord}, 32'h0001);
        tick();
        check("t4_word_count", words.size() - base, 32'd4096);
        zeros = 0;
        for (int i = base; i < words.size() && i < base + 4095; i++) begin
            if (words[i] == 16'h0000) zeros++;
        end
        check("t4_zero_words", zeros, 32'd4095);
        do_flush(wv, w, fd);
        check("t4_flush_no_word", {31'd0, wv}, 32'd0);

        // Code and flush together: 1010 padded -> 16'hA000 with flush done.
        send_code(16'd0, 16'h000A, 4'd3, 1'b1, busy);
        check("t5_busy", busy, 32'd2);
        check("t5_flush_done", {31'd0, bus.oFlushDone}, 32'd1);
        check("t5_word_valid", {31'd0, bus.oWordValid}, 32'd1);
        check("t5_word", {16'd0, bus.oWord}, 32'hA000);
        tick();

        // A code offered while busy must be dropped: only 1011 reaches the flush.
        wait_ready();
        base           = words.size();
        bus.iValid     = 1'b1;
        bus.iMSB       = 16'd0;
        bus.iLSB       = 16'h000B;
        bus.iRiceParam = 4'd3;
        tick();
        bus.iLSB       = 16'hFFFF;
        bus.iRiceParam = 4'd15;
        tick();
        bus.iValid = 1'b0;
        tick();
        tick();
        check("t7_no_extra_word", words.size() - base, 32'd0);
        do_flush(wv, w, fd);
        check("t7_flush_valid", {31'd0, wv}, 32'd1);
        check("t7_flush_word", {16'd0, w}, 32'hB000);
        check("t7_flush_done", {31'd0, fd}, 32'd1);

        // Reset in the middle of a q=40 code.
        wait_ready();
        bus.iValid     = 1'b1;
        bus.iMSB       = 16'd40;
        bus.iLSB       = 16'h0001;
        bus.iRiceParam = 4'd0;
        tick();
        bus.iValid = 1'b0;
        tick();
        check("t6_pre_reset_word", {31'd0, bus.oWordValid}, 32'd1);
        #2 iReset = 1'b0;
        #1;
        check("t6_ready", {31'd0, bus.oReady}, 32'd1);
        check("t6_word_valid", {31'd0, bus.oWordValid}, 32'd0);
        check("t6_word", {16'd0, bus.oWord}, 32'd0);
        check("t6_flush_done", {31'd0, bus.oFlushDone}, 32'd0);
        @(negedge iClock) iReset = 1'b1;
        tick();
        base = words.size();
        do_flush(wv, w, fd);
        check("t6_flush_no_word", {31'd0, wv}, 32'd0);
        check("t6_flush_done_after", {31'd0, fd}, 32'd1);
        tick();
        check("t6_word_count", words.size() - base, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
